// File: rtl/mul_man_pkg.sv
// ---------------------------------------------------------------------------
// mul_man_pkg
// Shared definitions for the mantissa-multiplier arbiter slice.
//   MANT_W   : width of one mantissa operand (12 bits)
//   RES_W    : width of the multiplier result slice, product bits [23:8]
//   mant_t   : one mantissa operand
//   result_t : one multiplier result
//   clog2()  : ceiling log2, usable in parameter and port declarations
// ---------------------------------------------------------------------------
package mul_man_pkg;

    localparam int MANT_W = 12;
    localparam int RES_W  = 16;

    typedef logic [MANT_W-1:0] mant_t;
    typedef logic [RES_W-1:0]  result_t;

    // Smallest r with (1 << r) >= value; clog2(1) = 0.
    // The loop stops at 30 so that 1 << i never reaches the sign bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_man_rsp_fifo.sv
// ---------------------------------------------------------------------------
// mul_man_rsp_fifo
// In-order response FIFO holding {requester id, product} pairs.
// The depth need not be a power of two; both pointers wrap explicitly.
// The head entry is presented show-ahead, and the id/result outputs read 0
// whenever the FIFO is empty (which includes the whole reset period).
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   push         : write push_id/push_data at the tail this cycle
//   push_id      : requester index of the entry being written
//   push_data    : product of the entry being written
//   rsp_valid    : FIFO not empty, head entry presented
//   rsp_ready    : consumer takes the head entry
//   rsp_id       : requester index of the head entry
//   rsp_result   : product of the head entry
// ---------------------------------------------------------------------------
module mul_man_rsp_fifo
    import mul_man_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int ID_W  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [ID_W-1:0] push_id,
    input  result_t         push_data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [ID_W-1:0] rsp_id,
    output result_t         rsp_result
);

    localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [ID_W-1:0] id_mem   [DEPTH];
    result_t         data_mem [DEPTH];

    logic full;
    logic pop;
    logic do_push;

    assign full = (count == CNT_W'(DEPTH));
    assign pop  = rsp_valid & rsp_ready;

    // A push into a full FIFO is only legal when the head leaves in the
    // same cycle; the slot being overwritten is the one being popped.
    assign do_push = push & (~full | pop);

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_push && !pop) begin
                count <= count + 1'b1;
            end else if (!do_push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage is not reset: an entry is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            id_mem[wr_ptr]   <= push_id;
            data_mem[wr_ptr] <= push_data;
        end
    end

    assign rsp_valid  = (count != '0);
    assign rsp_id     = rsp_valid ? id_mem[rd_ptr]   : '0;
    assign rsp_result = rsp_valid ? data_mem[rd_ptr] : '0;

endmodule

// File: rtl/mul_man_arb.sv
// ---------------------------------------------------------------------------
// mul_man_arb
// Round-robin arbiter sharing one external mantissa multiplier between
// N_REQ requesters. Accepted operations are tracked by a tag pipeline that
// matches the multiplier latency, and results are collected in an in-order
// response FIFO. A credit counter reserves a FIFO slot at grant time so that
// the FIFO can never overflow, whatever the consumer does.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : arbitration enable (low blocks new grants only)
//   req_valid   : per-requester request
//   req_op1/2   : packed 12-bit operands, slice i belongs to requester i
//   req_ready   : one-hot grant
//   mul_op1/2   : operands to the shared multiplier (0 when idle)
//   mul_result  : multiplier output, MUL_LAT cycles after the operands
//   rsp_valid   : response head valid
//   rsp_ready   : consumer accepts the head
//   rsp_id      : requester index of the head
//   rsp_result  : product of the head
//   idle        : nothing in flight and FIFO empty
// ---------------------------------------------------------------------------
module mul_man_arb
    import mul_man_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int MUL_LAT    = 1,
    parameter int FIFO_DEPTH = MUL_LAT + 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*MANT_W-1:0]   req_op1,
    input  logic [N_REQ*MANT_W-1:0]   req_op2,
    output logic [N_REQ-1:0]          req_ready,
    output mant_t                     mul_op1,
    output mant_t                     mul_op2,
    input  result_t                   mul_result,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [clog2(N_REQ)-1:0]   rsp_id,
    output result_t                   rsp_result,
    output logic                      idle
);

    localparam int ID_W  = clog2(N_REQ);
    localparam int CRD_W = clog2(FIFO_DEPTH + 1);

    logic [ID_W-1:0]    last_q;
    logic [CRD_W-1:0]   credit_q;
    logic [MUL_LAT-1:0] tag_valid;
    logic [ID_W-1:0]    tag_id [MUL_LAT];

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    int              cand;
    logic            can_grant;
    logic            accept;
    logic            pop;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last_q) + k) % N_REQ;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

    // Grants depend only on request state, the pointer, en and the registered
    // credit, so there is no combinational path from rsp_ready to req_ready.
    assign can_grant = rst_n & en & (credit_q != '0);
    assign accept    = can_grant & grant_found;
    assign req_ready = accept ? (N_REQ'(1) << grant_idx) : '0;

    assign mul_op1 = accept ? req_op1[grant_idx*MANT_W +: MANT_W] : '0;
    assign mul_op2 = accept ? req_op2[grant_idx*MANT_W +: MANT_W] : '0;

    assign pop = rsp_valid & rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= ID_W'(N_REQ - 1);
        end else if (accept) begin
            last_q <= grant_idx;
        end
    end

    // Credit is taken at grant and returned when the result leaves the FIFO,
    // so a pop only frees a slot for the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q <= CRD_W'(FIFO_DEPTH);
        end else begin
            case ({accept, pop})
                2'b10:   credit_q <= credit_q - 1'b1;
                2'b01:   credit_q <= credit_q + 1'b1;
                default: credit_q <= credit_q;
            endcase
        end
    end

    // Tag pipeline: stage MUL_LAT-1 lines up with mul_result for the same op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid <= '0;
            for (int s = 0; s < MUL_LAT; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            tag_valid[0] <= accept;
            tag_id[0]    <= grant_idx;
            for (int s = 1; s < MUL_LAT; s++) begin
                tag_valid[s] <= tag_valid[s-1];
                tag_id[s]    <= tag_id[s-1];
            end
        end
    end

    mul_man_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .ID_W  (ID_W)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (tag_valid[MUL_LAT-1]),
        .push_id    (tag_id[MUL_LAT-1]),
        .push_data  (mul_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result)
    );

    assign idle = ~(|tag_valid) & ~rsp_valid;

endmodule

// File: tb/tb_mul_man_arb.sv
// ---------------------------------------------------------------------------
// tb_mul_man_arb
// Directed bench for mul_man_arb with N_REQ=4, MUL_LAT=1, FIFO_DEPTH=3.
// A one-cycle multiplier model drives mul_result. Accepted operations are
// pushed to a scoreboard with their bench-computed product and popped in
// order as responses are consumed.
// ---------------------------------------------------------------------------
module tb_mul_man_arb;
    import mul_man_pkg::*;

    localparam int N_REQ      = 4;
    localparam int MUL_LAT    = 1;
    localparam int FIFO_DEPTH = MUL_LAT + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [3:0]    req_valid;
    logic [47:0]   req_op1;
    logic [47:0]   req_op2;
    logic [3:0]    req_ready;
    mant_t         mul_op1;
    mant_t         mul_op2;
    result_t       mul_result = '0;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    result_t       rsp_result;
    logic          idle;

    typedef struct {
        logic [1:0] id;
        result_t    result;
        int         cyc;
    } exp_t;

    exp_t        sb[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          cycle       = 0;
    int          last_grant;
    int          grants;
    int          exp_idx;
    logic [47:0] stage_op1 = '0;
    logic [47:0] stage_op2 = '0;
    int          mon_idx;
    mant_t       mon_a;
    mant_t       mon_b;
    exp_t        mon_e;

    mul_man_arb #(
        .N_REQ      (N_REQ),
        .MUL_LAT    (MUL_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .req_valid  (req_valid),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .req_ready  (req_ready),
        .mul_op1    (mul_op1),
        .mul_op2    (mul_op2),
        .mul_result (mul_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    function automatic result_t ref_product(input mant_t a, input mant_t b);
        logic [23:0] p;
        p = a * b;
        return p[23:8];
    endfunction

    // One-cycle multiplier model.
    always @(posedge clk) begin
        cycle++;
        mul_result <= ref_product(mul_op1, mul_op2);
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setOp(input int i, input mant_t a, input mant_t b);
        stage_op1[i*12 +: 12] = a;
        stage_op2[i*12 +: 12] = b;
    endtask

    // Drive one cycle of inputs just after the rising edge, then wait for the
    // falling edge so the caller samples outputs mid-cycle.
    task automatic applyStimulus(input logic [3:0] v, input logic e, input logic rr);
        @(posedge clk);
        #1;
        req_valid = v;
        en        = e;
        rsp_ready = rr;
        req_op1   = stage_op1;
        req_op2   = stage_op2;
        @(negedge clk);
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while (!idle && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("idle_timeout", 32'(idle), 1);
    endtask

    // Scoreboard monitor: checks grant legality, operand routing and every
    // presented response against the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("ready_onehot", 32'($onehot0(req_ready)), 1);
            checkOutput("ready_subset", 32'(req_ready & ~req_valid), 0);
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("rsp_unexpected", 32'(rsp_valid), 0);
                end else begin
                    checkOutput("rsp_id", 32'(rsp_id), 32'(sb[0].id));
                    checkOutput("rsp_result", 32'(rsp_result), 32'(sb[0].result));
                    checkOutput("rsp_latency", 32'(cycle >= sb[0].cyc + MUL_LAT + 1), 1);
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                    end
                end
            end
            if (|(req_valid & req_ready)) begin
                mon_idx = 0;
                for (int i = 0; i < N_REQ; i++) begin
                    if (req_valid[i] & req_ready[i]) begin
                        mon_idx = i;
                    end
                end
                mon_a = req_op1[mon_idx*12 +: 12];
                mon_b = req_op2[mon_idx*12 +: 12];
                checkOutput("mul_op", 32'({mul_op1, mul_op2}), 32'({mon_a, mon_b}));
                mon_e.id     = 2'(mon_idx);
                mon_e.result = ref_product(mon_a, mon_b);
                mon_e.cyc    = cycle;
                sb.push_back(mon_e);
            end else begin
                checkOutput("mul_op_idle", 32'({mul_op1, mul_op2}), 0);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset values, with requests pending to show the grant is blocked.
        rst_n     = 1'b0;
        en        = 1'b1;
        req_valid = 4'hF;
        req_op1   = '0;
        req_op2   = '0;
        rsp_ready = 1'b0;
        #2;
        checkOutput("rst_req_ready", 32'(req_ready), 0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("rst_idle", 32'(idle), 1);
        checkOutput("rst_rsp_id", 32'(rsp_id), 0);
        checkOutput("rst_rsp_result", 32'(rsp_result), 0);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n     = 1'b1;

        // Single request from requester 2.
        setOp(2, 12'h800, 12'h800);
        applyStimulus(4'b0100, 1'b1, 1'b1);
        checkOutput("single_grant", 32'(req_ready), 32'h4);
        checkOutput("single_mul_op1", 32'(mul_op1), 32'h800);
        applyStimulus(4'b0000, 1'b1, 1'b1);
        checkOutput("single_not_early", 32'(rsp_valid), 0);
        applyStimulus(4'b0000, 1'b1, 1'b1);
        checkOutput("single_rsp_valid", 32'(rsp_valid), 1);
        checkOutput("single_rsp_id", 32'(rsp_id), 2);
        checkOutput("single_rsp_result", 32'(rsp_result), 32'h4000);
        applyStimulus(4'b0000, 1'b1, 1'b1);
        checkOutput("single_idle", 32'(idle), 1);

        // Continuous requests from everyone: one grant per cycle, rotating.
        last_grant = 2;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                setOp(i, 12'($urandom), 12'($urandom));
            end
            applyStimulus(4'hF, 1'b1, 1'b1);
            exp_idx = (last_grant + 1) % N_REQ;
            checkOutput("rr_grant", 32'(req_ready), 32'(1 << exp_idx));
            last_grant = exp_idx;
        end
        applyStimulus(4'h0, 1'b1, 1'b1);
        waitIdle(20);
        checkOutput("rr_drained", 32'(sb.size()), 0);

        // Consumer stalled: exactly FIFO_DEPTH grants, then none.
        grants = 0;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                setOp(i, 12'($urandom), 12'($urandom));
            end
            applyStimulus(4'hF, 1'b1, 1'b0);
            if (|(req_ready & req_valid)) begin
                grants++;
            end
        end
        checkOutput("bp_grant_count", 32'(grants), FIFO_DEPTH);
        checkOutput("bp_ready_low", 32'(req_ready), 0);
        checkOutput("bp_rsp_valid", 32'(rsp_valid), 1);
        applyStimulus(4'h0, 1'b1, 1'b1);
        waitIdle(20);
        checkOutput("bp_drained", 32'(sb.size()), 0);

        // Toggling rsp_ready: held result is stable across the stall cycle.
        setOp(1, 12'hC00, 12'h800);
        applyStimulus(4'b0010, 1'b1, 1'b0);
        checkOutput("tog_grant", 32'(req_ready), 32'h2);
        applyStimulus(4'b0000, 1'b1, 1'b1);
        checkOutput("tog_not_early", 32'(rsp_valid), 0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("tog_rsp_valid", 32'(rsp_valid), 1);
        checkOutput("tog_rsp_id", 32'(rsp_id), 1);
        checkOutput("tog_rsp_result", 32'(rsp_result), 32'h6000);
        applyStimulus(4'b0000, 1'b1, 1'b1);
        checkOutput("tog_held_result", 32'(rsp_result), 32'h6000);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("tog_popped", 32'(rsp_valid), 0);

        // Enable dropped with one operation in flight.
        setOp(0, 12'($urandom), 12'($urandom));
        applyStimulus(4'b0001, 1'b1, 1'b1);
        checkOutput("en_grant", 32'(req_ready), 32'h1);
        applyStimulus(4'hF, 1'b0, 1'b1);
        checkOutput("en_blocked_1", 32'(req_ready), 0);
        checkOutput("en_busy", 32'(idle), 0);
        applyStimulus(4'hF, 1'b0, 1'b1);
        checkOutput("en_blocked_2", 32'(req_ready), 0);
        checkOutput("en_delivered", 32'(rsp_valid), 1);
        applyStimulus(4'hF, 1'b0, 1'b1);
        checkOutput("en_blocked_3", 32'(req_ready), 0);
        checkOutput("en_idle", 32'(idle), 1);
        applyStimulus(4'hF, 1'b1, 1'b1);
        checkOutput("en_resume", 32'(req_ready), 32'h2);
        applyStimulus(4'h0, 1'b1, 1'b1);
        waitIdle(20);
        checkOutput("en_drained", 32'(sb.size()), 0);

        // Reset with results buffered and in flight.
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                setOp(i, 12'($urandom), 12'($urandom));
            end
            applyStimulus(4'hF, 1'b1, 1'b0);
        end
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        checkOutput("mid_rst_req_ready", 32'(req_ready), 0);
        checkOutput("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("mid_rst_idle", 32'(idle), 1);
        checkOutput("mid_rst_rsp_id", 32'(rsp_id), 0);
        checkOutput("mid_rst_rsp_result", 32'(rsp_result), 0);
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(4'h0, 1'b1, 1'b1);
            checkOutput("post_rst_quiet", 32'(rsp_valid), 0);
        end
        setOp(0, 12'h800, 12'hC00);
        applyStimulus(4'hF, 1'b1, 1'b1);
        checkOutput("post_rst_first_grant", 32'(req_ready), 32'h1);
        applyStimulus(4'h0, 1'b1, 1'b1);
        waitIdle(20);
        checkOutput("post_rst_drained", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
